sync_frame_tx: RTL

Serial frame transmitter: accepts a parallel data word over a valid/ready handshake and drives it onto a one-bit serial line. Each frame is a fixed 4-bit sync pattern (default 1101), then the data word MSB first, then an idle gap of zeros. It is the transmit-side counterpart of the team's serial sequence detectors and feeds their `in` input directly. It also serves as the stimulus source for detector benches.

---
 rtl/sync_frame_tx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sync_frame_tx.sv
// ============================================================================
// Module   : sync_frame_tx
// Brief    : Serial frame transmitter: sync pattern, payload MSB first, zero gap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_frame_tx #(
  parameter int         DATA_W   = 8,
  parameter logic [3:0] SYNC_PAT = 4'b1101,
  parameter int         GAP      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              abort,
  output logic              out,
  output logic              busy,
  output logic              sof,
  output logic              last
);

  localparam int c_MAX = (DATA_W > GAP) ? ((DATA_W > 4) ? DATA_W : 4)
                                        : ((GAP > 4) ? GAP : 4);
  localparam int c_CW  = $clog2(c_MAX + 1);

  localparam logic [c_CW-1:0] c_SYNC_END = c_CW'(3);
  localparam logic [c_CW-1:0] c_DATA_END = c_CW'(DATA_W - 1);
  localparam logic [c_CW-1:0] c_GAP_END  = c_CW'((GAP > 0) ? (GAP - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              w_out_nxt, w_sof_nxt, w_last_nxt;
  logic              w_accept;

  // abort wins over a simultaneous handshake in IDLE
  assign w_accept = in_valid && in_ready && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      out      <= 1'b0;
      sof      <= 1'b0;
      last     <= 1'b0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      out      <= w_out_nxt;
      sof      <= w_sof_nxt;
      last     <= w_last_nxt;
      in_ready <= (w_state_nxt == S_IDLE);
      busy     <= (w_state_nxt != S_IDLE);
    end
  end

  // Outputs are computed for the cycle after the edge, so out/sof/last
  // line up with the state the block is entering.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_out_nxt   = 1'b0;
    w_sof_nxt   = 1'b0;
    w_last_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SYNC;
          w_cnt_nxt   = '0;
          w_shift_nxt = in_data;
          w_out_nxt   = SYNC_PAT[3];
          w_sof_nxt   = 1'b1;
        end
      end
      S_SYNC: begin
        if (r_cnt == c_SYNC_END) begin
          w_state_nxt = S_DATA;
          w_cnt_nxt   = '0;
          w_out_nxt   = r_shift[DATA_W-1];
          w_shift_nxt = r_shift << 1;
          w_last_nxt  = (c_DATA_END == '0);
        end else begin
          w_cnt_nxt = r_cnt + c_CW'(1);
          if (r_cnt == '0) begin
            w_out_nxt = SYNC_PAT[2];
          end else if (r_cnt == c_CW'(1)) begin
            w_out_nxt = SYNC_PAT[1];
          end else begin
            w_out_nxt = SYNC_PAT[0];
          end
        end
      end
      S_DATA: begin
        if (r_cnt == c_DATA_END) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + c_CW'(1);
          w_out_nxt   = r_shift[DATA_W-1];
          w_shift_nxt = r_shift << 1;
          w_last_nxt  = ((r_cnt + c_CW'(1)) == c_DATA_END);
        end
      end
      S_GAP: begin
        if (r_cnt == c_GAP_END) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_shift_nxt = '0;
      w_out_nxt   = 1'b0;
      w_sof_nxt   = 1'b0;
      w_last_nxt  = 1'b0;
    end
  end

endmodule

`default_nettype wire
